spi_disp_ctrl: RTL and testbench
================================

Name: spi_disp_ctrl

Overview:
- Sequencer that owns the board SPI link (spi_mosi/spi_clk/spi_cs) to the external MAX7219-style 2-digit display driver.
- After reset it plays a fixed init sequence, then pushes the mod-12 counter value as two BCD digits whenever the value changes.
- Sits in top between the mod12 counter and the SPI pins; drives one shared 16-bit word shifter.

Parameters:
- CLK_DIV, 4: clk cycles per spi_clk half-period (>=1).
- WORD_W, 16: bits per SPI word (address byte + data byte).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- value  in  4  current counter value (legal 0..11)
- spi_mosi  out  1  serial data, MSB first
- spi_clk  out  1  SPI clock, idle low (mode 0)
- spi_cs  out  1  chip select, active low
- busy  out  1  high while any word is in flight or queued
- init_done  out  1  high once the init sequence has completed

Behaviour:
- Reset values: spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, init_done=0, FSM=INIT, init index=0, last_sent=invalid.
- Reset assertion mid-word forces spi_cs high and spi_clk low immediately. No partial word is resumed. Init restarts from index 0.
- Word timing, with D=CLK_DIV and cycle 0 being the cycle spi_cs falls:
  - Bit i (MSB first) is driven on spi_mosi from cycle 2D*i.
  - spi_clk rises at 2D*i+D and falls at 2D*(i+1).
  - spi_cs rises at cycle 2D*WORD_W.
  - spi_cs then stays high for 2D cycles (inter-word gap).
  - Total word period is 2D*(WORD_W+1) cycles (136 at defaults).
- FSM states: INIT, SEND_LO, SEND_HI, IDLE.
  - INIT sends the 5 ROM words in order: 0x0C01, 0x0903, 0x0A08, 0x0B01, 0x0F00.
  - When INIT finishes, init_done goes high and stays high until reset. The FSM goes to IDLE.
  - IDLE: each cycle, if value != last_sent (always true when last_sent is invalid), snapshot value, assert busy, go to SEND_LO.
  - SEND_LO sends 0x01_0o, where o is the ones digit. SEND_HI then sends 0x02_0t, where t is the tens digit.
  - After SEND_HI, last_sent is set to the snapshot and the FSM returns to IDLE.
- Arithmetic:
  - value 0..9: t=0, o=value.
  - value 10..11: t=1, o=value-10.
  - value 12..15 (illegal): t=o=0xA (dash code); last_sent records the raw value.
- Changes during a transfer are not queued individually. IDLE compares against the latest value, so intermediate values are dropped and the newest wins. value is never sampled mid-word.
- busy:
  - High from the first cycle of INIT.
  - Falls the cycle after the last cs-high gap of SEND_HI (or of INIT) completes, if no new update is pending.
  - In IDLE, busy rises in the same cycle the change is detected.
- The first update after init is unconditional.

Optional Feature:
- Macro: SPI_DISP_BRIGHT_EN
- Defined:
  - Adds input port intensity[3:0].
  - The init word 0x0A08 uses 0x0A0 concatenated with intensity instead.
  - In IDLE, an intensity change (compared against last sent) sends one word 0x0A0x.
  - When intensity and value both change, the intensity word goes first, then SEND_LO and SEND_HI.
- Undefined: no port; intensity is fixed at 0x08, sent during init only.

Decomposition:
- Package disp_ctrl_pkg:
  - register address constants (DIGIT0=0x01, DIGIT1=0x02, DECODE=0x09, INTENSITY=0x0A, SCANLIM=0x0B, SHUTDOWN=0x0C, DISPTEST=0x0F)
  - DASH code 0xA
  - INIT_LEN=5 and the init ROM contents
  - FSM state enum
- Sub-module spi_word_tx (parameters CLK_DIV, WORD_W):
  - Inputs: start pulse, word.
  - Outputs: spi_mosi/spi_clk/spi_cs and a one-cycle done pulse after the cs-high gap.
  - start is ignored while active.

Test Plan:
- Release reset with value=0, CLK_DIV=4:
  - 5 words decoded from the pins are 0x0C01, 0x0903, 0x0A08, 0x0B01, 0x0F00, followed by 0x0100, 0x0200.
  - init_done rises at the end of word 5.
  - Each spi_cs low window lasts 128 clk cycles, with a 8-cycle high gap.
- Hold value=11 after init:
  - Exactly 0x0101, 0x0201 are sent, then busy=0.
  - No further traffic for 1000 cycles.
- Step value 3→4→5 during the SEND_LO word of 3:
  - Words sent are 0x0103, 0x0200, 0x0105, 0x0200; value 4 is never sent.
- value=13:
  - Words sent are 0x010A, 0x020A.
  - value then 13→0 sends 0x0100, 0x0200.
- Assert reset at bit 7 of an update word:
  - spi_cs=1 and spi_clk=0 within the same time step.
  - After release, the full init sequence is replayed.
- With SPI_DISP_BRIGHT_EN, change intensity 8→3 and value 2→7 in the same cycle:
  - Words sent are 0x0A03, 0x0107, 0x0200.

Source files
------------

// File: rtl/disp_ctrl_pkg.sv
// Shared constants, init ROM and FSM states for the SPI display sequencer.
// The SPI_DISP_BRIGHT_EN build uses the StSendInt state for runtime brightness words.
package disp_ctrl_pkg;

  localparam logic [7:0] DIGIT0    = 8'h01;
  localparam logic [7:0] DIGIT1    = 8'h02;
  localparam logic [7:0] DECODE    = 8'h09;
  localparam logic [7:0] INTENSITY = 8'h0A;
  localparam logic [7:0] SCANLIM   = 8'h0B;
  localparam logic [7:0] SHUTDOWN  = 8'h0C;
  localparam logic [7:0] DISPTEST  = 8'h0F;

  localparam logic [3:0] DASH          = 4'hA;
  localparam logic [3:0] DEF_INTENSITY = 4'h8;
  localparam int unsigned INIT_LEN     = 5;

  typedef enum logic [2:0] {
    StInit,
    StSendLo,
    StSendHi,
    StIdle,
    StSendInt
  } state_e;

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {SHUTDOWN, 8'h01};
      3'd1:    w = {DECODE, 8'h03};
      3'd2:    w = {INTENSITY, 4'h0, inten};
      3'd3:    w = {SCANLIM, 8'h01};
      3'd4:    w = {DISPTEST, 8'h00};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Returns {tens, ones}; out-of-range counts show dashes on both digits.
  function automatic logic [7:0] bcd(input logic [3:0] v);
    logic [7:0] d;
    if (v < 4'd10)      d = {4'h0, v};
    else if (v < 4'd12) d = {4'h1, v - 4'd10};
    else                d = {DASH, DASH};
    return d;
  endfunction

endpackage

// File: rtl/spi_word_tx.sv
// Mode-0 SPI word shifter: MSB first, CLK_DIV clk cycles per half period,
// followed by a 2*CLK_DIV cycle chip-select-high gap before it is ready again.
module spi_word_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned WORD_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              spi_mosi_o,
  output logic              spi_clk_o,
  output logic              spi_cs_o,
  output logic              ready_o,
  output logic              done_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(WORD_W + 1);
  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WORD_W);

  logic              active_q, half_q, mosi_q, sclk_q, cs_q;
  logic [DivW-1:0]   div_q;
  logic [BitW-1:0]   bit_q;
  logic [WORD_W-1:0] sreg_q;
  logic              last_cyc;

  // Last gap cycle: a new start here keeps words back to back with no idle cycle.
  assign last_cyc = active_q && (bit_q == BitLast) && half_q && (div_q == DivMax);
  assign ready_o  = !active_q || last_cyc;
  assign done_o   = last_cyc;

  assign spi_mosi_o = mosi_q;
  assign spi_clk_o  = sclk_q;
  assign spi_cs_o   = cs_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      half_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sreg_q   <= '0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
    end else if (ready_o && start_i) begin
      active_q <= 1'b1;
      half_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sreg_q   <= word_i;
      mosi_q   <= word_i[WORD_W-1];
      sclk_q   <= 1'b0;
      cs_q     <= 1'b0;
    end else if (last_cyc) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      if (div_q == DivMax) begin
        div_q <= '0;
        if (!half_q) begin
          half_q <= 1'b1;
          sclk_q <= (bit_q != BitLast);
        end else begin
          half_q <= 1'b0;
          sclk_q <= 1'b0;
          bit_q  <= bit_q + 1'b1;
          sreg_q <= sreg_q << 1;
          if (bit_q == BitLast - 1'b1) begin
            cs_q   <= 1'b1;
            mosi_q <= 1'b0;
          end else begin
            mosi_q <= sreg_q[WORD_W-2];
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_disp_ctrl.sv
// MAX7219-style display sequencer: init ROM, then BCD digit updates on value change.
// Define SPI_DISP_BRIGHT_EN to add a runtime intensity input.
module spi_disp_ctrl
  import disp_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned WORD_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
`ifdef SPI_DISP_BRIGHT_EN
  input  logic [3:0] intensity,
`endif
  output logic       spi_mosi,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       busy,
  output logic       init_done
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        last_vld_q, last_vld_d;
  logic [3:0]  last_q, last_d, snap_q, snap_d;
  logic        init_done_q, init_done_d, busy_q;
  logic [3:0]  int_cur;
  logic        val_chg, int_chg;
  logic        tx_start, tx_ready, tx_done;
  logic [15:0] word16;
  logic [7:0]  digits;

`ifdef SPI_DISP_BRIGHT_EN
  logic [3:0] int_snap_q, int_snap_d, int_last_q, int_last_d;
  assign int_cur = intensity;
  assign int_chg = (int_cur != int_last_q);
`else
  assign int_cur = DEF_INTENSITY;
  assign int_chg = 1'b0;
`endif

  assign val_chg = !last_vld_q || (value != last_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_vld_d  = last_vld_q;
    last_d      = last_q;
    snap_d      = snap_q;
    init_done_d = init_done_q;
`ifdef SPI_DISP_BRIGHT_EN
    int_snap_d  = int_snap_q;
    int_last_d  = int_last_q;
`endif
    unique case (state_q)
      StInit: begin
        if (tx_done) begin
          if (idx_q == 3'(INIT_LEN - 1)) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StIdle: begin
`ifdef SPI_DISP_BRIGHT_EN
        if (int_chg) begin
          int_snap_d = int_cur;
          state_d    = StSendInt;
        end else
`endif
        if (val_chg) begin
          snap_d  = value;
          state_d = StSendLo;
        end
      end
      StSendInt: begin
`ifdef SPI_DISP_BRIGHT_EN
        if (tx_done) begin
          int_last_d = int_snap_q;
          if (val_chg) begin
            snap_d  = value;
            state_d = StSendLo;
          end else begin
            state_d = StIdle;
          end
        end
`endif
      end
      StSendLo: if (tx_done) state_d = StSendHi;
      StSendHi: begin
        if (tx_done) begin
          last_vld_d = 1'b1;
          last_d     = snap_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef SPI_DISP_BRIGHT_EN
    // Remember the intensity actually shifted out by the init ROM.
    if (tx_ready && state_d == StInit && idx_d == 3'd2) int_last_d = int_cur;
`endif
  end

  // The next word is chosen from next-state so it can launch in the done cycle.
  always_comb begin
    digits = bcd(snap_d);
    unique case (state_d)
      StInit:    word16 = init_word(idx_d, int_cur);
      StSendLo:  word16 = {DIGIT0, 4'h0, digits[3:0]};
      StSendHi:  word16 = {DIGIT1, 4'h0, digits[7:4]};
`ifdef SPI_DISP_BRIGHT_EN
      StSendInt: word16 = {INTENSITY, 4'h0, int_snap_d};
`endif
      default:   word16 = 16'h0000;
    endcase
  end

  assign tx_start  = tx_ready && (state_d != StIdle);
  assign busy      = busy_q || ((state_q == StIdle) && (val_chg || int_chg));
  assign init_done = init_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      idx_q       <= 3'd0;
      last_vld_q  <= 1'b0;
      last_q      <= 4'h0;
      snap_q      <= 4'h0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_DISP_BRIGHT_EN
      int_snap_q  <= DEF_INTENSITY;
      int_last_q  <= DEF_INTENSITY;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_vld_q  <= last_vld_d;
      last_q      <= last_d;
      snap_q      <= snap_d;
      init_done_q <= init_done_d;
      busy_q      <= (state_d != StIdle);
`ifdef SPI_DISP_BRIGHT_EN
      int_snap_q  <= int_snap_d;
      int_last_q  <= int_last_d;
`endif
    end
  end

  spi_word_tx #(
    .CLK_DIV(CLK_DIV),
    .WORD_W (WORD_W)
  ) u_tx (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (tx_start),
    .word_i    (WORD_W'(word16)),
    .spi_mosi_o(spi_mosi),
    .spi_clk_o (spi_clk),
    .spi_cs_o  (spi_cs),
    .ready_o   (tx_ready),
    .done_o    (tx_done)
  );

endmodule

// File: tb/tb_spi_disp_ctrl.sv
// Bench for spi_disp_ctrl: decodes SPI pins into words and scores them against a queue.
// Build with SPI_DISP_BRIGHT_EN to add the intensity sequence.
module tb_spi_disp_ctrl;

  localparam int unsigned D   = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned WIN = 2 * D * W;
  localparam int unsigned GAP = 2 * D;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] value = 4'd0;
`ifdef SPI_DISP_BRIGHT_EN
  logic [3:0] intensity = 4'h8;
`endif
  logic spi_mosi, spi_clk, spi_cs, busy, init_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int word_cnt = 0;
  int init_words = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0]  val;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_disp_ctrl #(
    .CLK_DIV(D),
    .WORD_W (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
`ifdef SPI_DISP_BRIGHT_EN
    .intensity(intensity),
`endif
    .spi_mosi (spi_mosi),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .busy     (busy),
    .init_done(init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pin-level decoder; partial words cut off by reset are discarded.
  logic [15:0] sh = '0;
  int   nbits = 0, fall_cyc = 0, rise_cyc = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0, seen_rise = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      nbits = 0; cs_prev = 1'b1; sclk_prev = 1'b0; seen_rise = 1'b0; init_words = 0;
    end else begin
      if (cs_prev && !spi_cs) begin
        fall_cyc = cyc;
        nbits    = 0;
        if (seen_rise && init_words >= 1 && init_words <= 4)
          check("init_gap", cyc - rise_cyc, GAP);
      end
      if (!spi_cs && !sclk_prev && spi_clk) begin
        sh = {sh[14:0], spi_mosi};
        nbits++;
      end
      if (!cs_prev && spi_cs) begin
        rise_cyc  = cyc;
        seen_rise = 1'b1;
        word_cnt++;
        init_words++;
        check("cs_window", cyc - fall_cyc, WIN);
        check("bit_count", nbits, W);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %04h expected none", sh);
        end else begin
          check("word", sh, exp_q.pop_front());
        end
      end
      cs_prev   = spi_cs;
      sclk_prev = spi_clk;
    end
  end

  task automatic push_init();
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h0903);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B01);
    exp_q.push_back(16'h0F00);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    tick();
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_in_time"}, (n < budget), 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_cs_low(input string name);
    int n = 0;
    while (spi_cs && n < 500) begin
      tick();
      n++;
    end
    check({name, "_cs_fall"}, spi_cs, 0);
  endtask

  initial begin
    int n;
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{4'd11, 16'h0101, 16'h0201};
    tbl[1] = '{4'd5,  16'h0105, 16'h0200};
    tbl[2] = '{4'd13, 16'h010A, 16'h020A};
    tbl[3] = '{4'd0,  16'h0100, 16'h0200};
    tbl[4] = '{4'd9,  16'h0109, 16'h0200};
    tbl[5] = '{4'd10, 16'h0100, 16'h0201};
    tbl[6] = '{4'd12, 16'h010A, 16'h020A};
    tbl[7] = '{4'd15, 16'h010A, 16'h020A};

    #1 reset = 1'b1;
    repeat (3) tick();
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);

    push_init();
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0200);
    reset = 1'b0;

    // init_done must rise exactly after the gap that follows word 5
    n = 0;
    while (word_cnt < 5 && n < 1000) begin
      tick();
      n++;
    end
    check("init_words_in_time", (word_cnt >= 5), 1);
    check("init_done_at_cs_rise", init_done, 0);
    repeat (GAP - 1) tick();
    check("init_done_last_gap", init_done, 0);
    tick();
    check("init_done_after_gap", init_done, 1);
    wait_idle("init", 2000);

    for (int i = 0; i < 8; i++) begin
      value = tbl[i].val;
      exp_q.push_back(tbl[i].lo);
      exp_q.push_back(tbl[i].hi);
      #1;
      check("busy_rise_same_cycle", busy, 1);
      wait_idle("table", 1000);
      if (i == 0) begin
        n = word_cnt;
        repeat (1000) tick();
        check("quiet_hold_11", word_cnt, n);
        check("quiet_busy", busy, 0);
      end
    end

    // Intermediate value 4 lands mid-word and must be superseded by 5
    value = 4'd3;
    exp_q.push_back(16'h0103);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0105);
    exp_q.push_back(16'h0200);
    tick();
    wait_cs_low("step");
    repeat (20) tick();
    value = 4'd4;
    repeat (20) tick();
    value = 4'd5;
    wait_idle("step", 1500);

    // Reset during bit 7 of an update word
    value = 4'd7;
    tick();
    wait_cs_low("midrst");
    repeat (2 * D * 7 + 2) tick();
    reset = 1'b1;
    #1;
    check("midrst_cs", spi_cs, 1);
    check("midrst_sclk", spi_clk, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_busy", busy, 0);
    repeat (3) tick();
    push_init();
    exp_q.push_back(16'h0107);
    exp_q.push_back(16'h0200);
    reset = 1'b0;
    wait_idle("replay", 2500);
    check("replay_init_done", init_done, 1);

`ifdef SPI_DISP_BRIGHT_EN
    value = 4'd2;
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0200);
    wait_idle("bright_pre", 1000);
    intensity = 4'h3;
    value     = 4'd7;
    exp_q.push_back(16'h0A03);
    exp_q.push_back(16'h0107);
    exp_q.push_back(16'h0200);
    wait_idle("bright", 1500);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
